// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module : decode_stage_if
// Desc   : Fetch, write-back and D/E pipeline signals of the RV32I decode stage.
// Rev    : 1.0  initial release
// ============================================================================
interface decode_stage_if #(
   parameter int XLEN = 32
);
   logic [31:0]     instrD;
   logic [XLEN-1:0] PCD;
   logic            flushE;
   logic            regWriteW;
   logic [4:0]      rdW;
   logic [XLEN-1:0] resultW;

   logic            regWriteE;
   logic [1:0]      resultSrcE;
   logic            memWriteE;
   logic            branchE;
   logic            jumpE;
   logic [2:0]      ALUcontrolE;
   logic            ALUsrcE;
   logic [XLEN-1:0] RD1E;
   logic [XLEN-1:0] RD2E;
   logic [XLEN-1:0] immExtE;
   logic [XLEN-1:0] PCE;
   logic [4:0]      rs1E;
   logic [4:0]      rs2E;
   logic [4:0]      rdE;
   logic            illegalE;

   modport master (
      output instrD, PCD, flushE, regWriteW, rdW, resultW,
      input  regWriteE, resultSrcE, memWriteE, branchE, jumpE, ALUcontrolE,
             ALUsrcE, RD1E, RD2E, immExtE, PCE, rs1E, rs2E, rdE, illegalE
   );

   modport slave (
      input  instrD, PCD, flushE, regWriteW, rdW, resultW,
      output regWriteE, resultSrcE, memWriteE, branchE, jumpE, ALUcontrolE,
             ALUsrcE, RD1E, RD2E, immExtE, PCE, rs1E, rs2E, rdE, illegalE
   );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module : decode_stage
// Desc   : RV32I decode: control decode, immediate extension, 32x32 register
//          file and D/E pipeline register. Define DECODE_WB_BYPASS_EN to
//          forward the write-back result into the read ports.
// Rev    : 1.0  initial release
// ============================================================================
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic          clk,
   input  logic          rst,
   decode_stage_if.slave bus
);

   localparam logic [6:0] c_opLoad   = 7'b0000011;
   localparam logic [6:0] c_opStore  = 7'b0100011;
   localparam logic [6:0] c_opRType  = 7'b0110011;
   localparam logic [6:0] c_opIAlu   = 7'b0010011;
   localparam logic [6:0] c_opBranch = 7'b1100011;
   localparam logic [6:0] c_opJal    = 7'b1101111;
   localparam logic [6:0] c_opLui    = 7'b0110111;

   localparam logic [2:0] c_immNone = 3'd0;
   localparam logic [2:0] c_immI    = 3'd1;
   localparam logic [2:0] c_immS    = 3'd2;
   localparam logic [2:0] c_immB    = 3'd3;
   localparam logic [2:0] c_immJ    = 3'd4;
   localparam logic [2:0] c_immU    = 3'd5;

   logic [31:0]     w_instr;
   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic            w_funct7b5;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;

   logic            w_regWrite;
   logic [1:0]      w_resultSrc;
   logic            w_memWrite;
   logic            w_branch;
   logic            w_jump;
   logic [2:0]      w_aluFunct;
   logic [2:0]      w_aluControl;
   logic            w_aluSrc;
   logic [2:0]      w_immSel;
   logic            w_illegal;
   logic [XLEN-1:0] w_immExt;
   logic [XLEN-1:0] w_rd1;
   logic [XLEN-1:0] w_rd2;

   logic [XLEN-1:0] r_regs [NREGS];

   logic            r_regWriteE;
   logic [1:0]      r_resultSrcE;
   logic            r_memWriteE;
   logic            r_branchE;
   logic            r_jumpE;
   logic [2:0]      r_aluControlE;
   logic            r_aluSrcE;
   logic [XLEN-1:0] r_rd1E;
   logic [XLEN-1:0] r_rd2E;
   logic [XLEN-1:0] r_immExtE;
   logic [XLEN-1:0] r_pcE;
   logic [4:0]      r_rs1E;
   logic [4:0]      r_rs2E;
   logic [4:0]      r_rdE;
   logic            r_illegalE;

   assign w_instr    = bus.instrD;
   assign w_opcode   = w_instr[6:0];
   assign w_rd       = w_instr[11:7];
   assign w_funct3   = w_instr[14:12];
   assign w_rs1      = w_instr[19:15];
   assign w_rs2      = w_instr[24:20];
   assign w_funct7b5 = w_instr[30];

   // funct3 -> ALU operation shared by R-type and I-ALU
   always_comb begin
      w_aluFunct = 3'b000;
      case (w_funct3)
         3'b000:  w_aluFunct = 3'b000;
         3'b001:  w_aluFunct = 3'b110;
         3'b010:  w_aluFunct = 3'b101;
         3'b100:  w_aluFunct = 3'b100;
         3'b101:  w_aluFunct = 3'b111;
         3'b110:  w_aluFunct = 3'b011;
         3'b111:  w_aluFunct = 3'b010;
         default: w_aluFunct = 3'b000;
      endcase
   end

   always_comb begin
      w_regWrite   = 1'b0;
      w_resultSrc  = 2'b00;
      w_memWrite   = 1'b0;
      w_branch     = 1'b0;
      w_jump       = 1'b0;
      w_aluControl = 3'b000;
      w_aluSrc     = 1'b0;
      w_immSel     = c_immNone;
      w_illegal    = 1'b0;
      case (w_opcode)
         c_opLoad: begin
            w_regWrite  = 1'b1;
            w_resultSrc = 2'b01;
            w_aluSrc    = 1'b1;
            w_immSel    = c_immI;
         end
         c_opStore: begin
            w_memWrite = 1'b1;
            w_aluSrc   = 1'b1;
            w_immSel   = c_immS;
         end
         c_opRType: begin
            w_regWrite   = 1'b1;
            w_aluControl = (w_funct3 == 3'b000 && w_funct7b5) ? 3'b001 : w_aluFunct;
         end
         c_opIAlu: begin
            w_regWrite   = 1'b1;
            w_aluSrc     = 1'b1;
            w_aluControl = w_aluFunct;
            w_immSel     = c_immI;
         end
         c_opBranch: begin
            w_branch     = 1'b1;
            w_aluControl = 3'b001;
            w_immSel     = c_immB;
         end
         c_opJal: begin
            w_regWrite  = 1'b1;
            w_jump      = 1'b1;
            w_resultSrc = 2'b10;
            w_immSel    = c_immJ;
         end
         c_opLui: begin
            w_regWrite = 1'b1;
            w_aluSrc   = 1'b1;
            w_immSel   = c_immU;
         end
         // the all-zero word is the fetch bubble and must not trap
         default: w_illegal = (w_instr != 32'h0000_0000);
      endcase
   end

   always_comb begin
      w_immExt = '0;
      case (w_immSel)
         c_immI:  w_immExt = {{20{w_instr[31]}}, w_instr[31:20]};
         c_immS:  w_immExt = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
         c_immB:  w_immExt = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                              w_instr[30:25], w_instr[11:8], 1'b0};
         c_immJ:  w_immExt = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                              w_instr[20], w_instr[30:21], 1'b0};
         c_immU:  w_immExt = {w_instr[31:12], 12'b0};
         default: w_immExt = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (bus.regWriteW && bus.rdW != 5'd0) begin
         r_regs[bus.rdW] <= bus.resultW;
      end
   end

`ifdef DECODE_WB_BYPASS_EN
   assign w_rd1 = (w_rs1 == 5'd0) ? '0 :
                  (bus.regWriteW && bus.rdW == w_rs1) ? bus.resultW : r_regs[w_rs1];
   assign w_rd2 = (w_rs2 == 5'd0) ? '0 :
                  (bus.regWriteW && bus.rdW == w_rs2) ? bus.resultW : r_regs[w_rs2];
`else
   assign w_rd1 = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
   assign w_rd2 = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst || bus.flushE) begin
         r_regWriteE   <= 1'b0;
         r_resultSrcE  <= 2'b00;
         r_memWriteE   <= 1'b0;
         r_branchE     <= 1'b0;
         r_jumpE       <= 1'b0;
         r_aluControlE <= 3'b000;
         r_aluSrcE     <= 1'b0;
         r_rd1E        <= '0;
         r_rd2E        <= '0;
         r_immExtE     <= '0;
         r_pcE         <= '0;
         r_rs1E        <= 5'd0;
         r_rs2E        <= 5'd0;
         r_rdE         <= 5'd0;
         r_illegalE    <= 1'b0;
      end else begin
         r_regWriteE   <= w_regWrite;
         r_resultSrcE  <= w_resultSrc;
         r_memWriteE   <= w_memWrite;
         r_branchE     <= w_branch;
         r_jumpE       <= w_jump;
         r_aluControlE <= w_aluControl;
         r_aluSrcE     <= w_aluSrc;
         r_rd1E        <= w_rd1;
         r_rd2E        <= w_rd2;
         r_immExtE     <= w_immExt;
         r_pcE         <= bus.PCD;
         r_rs1E        <= w_rs1;
         r_rs2E        <= w_rs2;
         r_rdE         <= w_rd;
         r_illegalE    <= w_illegal;
      end
   end

   assign bus.regWriteE   = r_regWriteE;
   assign bus.resultSrcE  = r_resultSrcE;
   assign bus.memWriteE   = r_memWriteE;
   assign bus.branchE     = r_branchE;
   assign bus.jumpE       = r_jumpE;
   assign bus.ALUcontrolE = r_aluControlE;
   assign bus.ALUsrcE     = r_aluSrcE;
   assign bus.RD1E        = r_rd1E;
   assign bus.RD2E        = r_rd2E;
   assign bus.immExtE     = r_immExtE;
   assign bus.PCE         = r_pcE;
   assign bus.rs1E        = r_rs1E;
   assign bus.rs2E        = r_rs2E;
   assign bus.rdE         = r_rdE;
   assign bus.illegalE    = r_illegalE;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_decode_stage
// Desc   : Self-checking bench for decode_stage: directed vector table, corner
//          sequences and random instructions against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_decode_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;

   decode_stage_if bus ();

   decode_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef DECODE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic        regWrite;
      logic [1:0]  resultSrc;
      logic        memWrite;
      logic        branch;
      logic        jump;
      logic [2:0]  alu;
      logic        aluSrc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        illegal;
   } eOut_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        flush;
      bit          chkImm;
      eOut_t       exp;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mRegs [32];
   int          aluOf [8];
   vec_t        vecs [$];

   function automatic eOut_t sampleOut();
      eOut_t s;
      s.regWrite  = bus.regWriteE;
      s.resultSrc = bus.resultSrcE;
      s.memWrite  = bus.memWriteE;
      s.branch    = bus.branchE;
      s.jump      = bus.jumpE;
      s.alu       = bus.ALUcontrolE;
      s.aluSrc    = bus.ALUsrcE;
      s.rd1       = bus.RD1E;
      s.rd2       = bus.RD2E;
      s.imm       = bus.immExtE;
      s.pc        = bus.PCE;
      s.rs1       = bus.rs1E;
      s.rs2       = bus.rs2E;
      s.rd        = bus.rdE;
      s.illegal   = bus.illegalE;
      return s;
   endfunction

   task automatic checkOut(input string name, input eOut_t exp, input bit chkImm);
      eOut_t act;
      act = sampleOut();
      if (!chkImm) begin
         act.imm = '0;
         exp.imm = '0;
      end
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
      logic [31:0] m;
      m = 32'h1 << (bits - 1);
      return (v ^ m) - m;
   endfunction

   function automatic logic [31:0] readReg(input logic [4:0] idx, input logic wbEn,
                                           input logic [4:0] wbRd, input logic [31:0] wbData);
      if (idx == 5'd0) return 32'h0;
      if (BYP && wbEn && wbRd == idx) return wbData;
      return mRegs[idx];
   endfunction

   // Reference: the E outputs that should appear after the next edge.
   task automatic predict(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                          input logic wbEn, input logic [4:0] wbRd, input logic [31:0] wbData,
                          output eOut_t e, output bit chk);
      logic [6:0] op;
      logic [2:0] f3;
      e   = '0;
      chk = 1'b1;
      if (fl) return;
      op    = ins[6:0];
      f3    = ins[14:12];
      e.pc  = pc;
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.rd  = ins[11:7];
      e.rd1 = readReg(e.rs1, wbEn, wbRd, wbData);
      e.rd2 = readReg(e.rs2, wbEn, wbRd, wbData);
      case (op)
         7'h03: begin e.regWrite = 1; e.resultSrc = 2'b01; e.aluSrc = 1; e.imm = sext(ins >> 20, 12); end
         7'h23: begin e.memWrite = 1; e.aluSrc = 1;
                      e.imm = sext(((ins >> 25) << 5) | ((ins >> 7) & 32'h1f), 12); end
         7'h33: begin e.regWrite = 1; chk = 0;
                      e.alu = (f3 == 3'd0 && ins[30]) ? 3'd1 : 3'(aluOf[f3]); end
         7'h13: begin e.regWrite = 1; e.aluSrc = 1; e.alu = 3'(aluOf[f3]);
                      e.imm = sext(ins >> 20, 12); end
         7'h63: begin e.branch = 1; e.alu = 3'd1;
                      e.imm = sext((((ins >> 31) & 32'h1) << 12) | (((ins >> 7) & 32'h1) << 11) |
                                   (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1), 13); end
         7'h6f: begin e.regWrite = 1; e.jump = 1; e.resultSrc = 2'b10;
                      e.imm = sext((((ins >> 31) & 32'h1) << 20) | (((ins >> 12) & 32'hff) << 12) |
                                   (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3ff) << 1), 21); end
         7'h37: begin e.regWrite = 1; e.aluSrc = 1; e.imm = ins & 32'hffff_f000; end
         default: begin e.illegal = (ins != 32'h0); chk = (ins == 32'h0); end
      endcase
   endtask

   task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                       input logic wbEn, input logic [4:0] wbRd, input logic [31:0] wbData);
      @(negedge clk);
      bus.instrD    = ins;
      bus.PCD       = pc;
      bus.flushE    = fl;
      bus.regWriteW = wbEn;
      bus.rdW       = wbRd;
      bus.resultW   = wbData;
      @(posedge clk);
      #1;
      if (wbEn && wbRd != 5'd0) mRegs[wbRd] = wbData;
   endtask

   task automatic addVec(input logic [31:0] ins, input logic [31:0] pc, input logic fl, input bit ck,
                         input logic rw, input logic [1:0] rs, input logic mw, input logic br,
                         input logic jp, input logic [2:0] alu, input logic src,
                         input logic [31:0] imm, input logic ill);
      vec_t v;
      v.instr  = ins;
      v.pc     = pc;
      v.flush  = fl;
      v.chkImm = ck;
      v.exp    = '0;
      if (!fl) begin
         v.exp.regWrite  = rw;
         v.exp.resultSrc = rs;
         v.exp.memWrite  = mw;
         v.exp.branch    = br;
         v.exp.jump      = jp;
         v.exp.alu       = alu;
         v.exp.aluSrc    = src;
         v.exp.imm       = imm;
         v.exp.illegal   = ill;
         v.exp.pc        = pc;
         v.exp.rs1       = ins[19:15];
         v.exp.rs2       = ins[24:20];
         v.exp.rd        = ins[11:7];
      end
      vecs.push_back(v);
   endtask

   function automatic bit isSupported(input logic [6:0] op);
      return op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h13 ||
             op == 7'h63 || op == 7'h6f || op == 7'h37;
   endfunction

   function automatic logic [31:0] randInstr();
      logic [31:0] w;
      logic [2:0]  f3;
      int          sel;
      w   = $urandom;
      f3  = 3'($urandom_range(0, 7));
      if (f3 == 3'd3) f3 = 3'd2;
      sel = int'($urandom_range(0, 9));
      case (sel)
         0:       begin w[14:12] = 3'b010; w[6:0] = 7'h03; end
         1:       begin w[14:12] = 3'b010; w[6:0] = 7'h23; end
         2, 9:    begin w[31] = 1'b0; w[29:25] = 5'd0; w[14:12] = f3; w[6:0] = 7'h33; end
         3:       begin w[14:12] = f3; w[6:0] = 7'h13; end
         4:       begin w[14:12] = 3'b000; w[6:0] = 7'h63; end
         5:       w[6:0] = 7'h6f;
         6:       w[6:0] = 7'h37;
         7:       w = 32'h0;
         default: begin
            repeat (16) if (isSupported(w[6:0])) w = $urandom;
            if (isSupported(w[6:0])) w[6:0] = 7'h7f;
         end
      endcase
      return w;
   endfunction

   initial begin
      eOut_t       e;
      bit          ck;
      logic [31:0] ins, pc, wbData;
      logic        fl, wbEn;
      logic [4:0]  wbRd;

      aluOf = '{0, 6, 5, 0, 4, 7, 3, 2};
      for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
      bus.instrD = 32'h0; bus.PCD = 32'h0; bus.flushE = 1'b0;
      bus.regWriteW = 1'b0; bus.rdW = 5'd0; bus.resultW = 32'h0;

      repeat (2) @(posedge clk);
      #1 checkOut("rstHold", '0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      #1 checkOut("rstRelease", '0, 1'b1);

      //      instr         pc          fl ck rw rs     mw br jp alu    src imm            ill
      addVec(32'h00500093, 32'h100, 0, 1, 1, 2'b00, 0, 0, 0, 3'b000, 1, 32'h0000_0005, 0);
      addVec(32'hfe208ee3, 32'h104, 0, 1, 0, 2'b00, 0, 1, 0, 3'b001, 0, 32'hffff_fffc, 0);
      addVec(32'h0020a423, 32'h108, 0, 1, 0, 2'b00, 1, 0, 0, 3'b000, 1, 32'h0000_0008, 0);
      addVec(32'hffc12283, 32'h10c, 0, 1, 1, 2'b01, 0, 0, 0, 3'b000, 1, 32'hffff_fffc, 0);
      addVec(32'h402081b3, 32'h110, 0, 0, 1, 2'b00, 0, 0, 0, 3'b001, 0, 32'h0,         0);
      addVec(32'h007372b3, 32'h114, 0, 0, 1, 2'b00, 0, 0, 0, 3'b010, 0, 32'h0,         0);
      addVec(32'h00309093, 32'h118, 0, 1, 1, 2'b00, 0, 0, 0, 3'b110, 1, 32'h0000_0003, 0);
      addVec(32'hc0000113, 32'h11c, 0, 1, 1, 2'b00, 0, 0, 0, 3'b000, 1, 32'hffff_fc00, 0);
      addVec(32'h010000ef, 32'h120, 0, 1, 1, 2'b10, 0, 0, 1, 3'b000, 0, 32'h0000_0010, 0);
      addVec(32'h12345237, 32'h124, 0, 1, 1, 2'b00, 0, 0, 0, 3'b000, 1, 32'h1234_5000, 0);
      addVec(32'h0000006f, 32'h128, 1, 1, 0, 2'b00, 0, 0, 0, 3'b000, 0, 32'h0,         0);
      addVec(32'h00000000, 32'h0,   0, 1, 0, 2'b00, 0, 0, 0, 3'b000, 0, 32'h0,         0);
      addVec(32'h0000007f, 32'h130, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 32'h0,         1);

      for (int k = 0; k < vecs.size(); k++) begin
         step(vecs[k].instr, vecs[k].pc, vecs[k].flush, 1'b0, 5'd0, 32'h0);
         checkOut($sformatf("vec%0d", k), vecs[k].exp, vecs[k].chkImm);
      end

      // write x3 while reading it (addi x5,x3,0), then read again
      step(32'h00018293, 32'h200, 1'b0, 1'b1, 5'd3, 32'hdead_beef);
      checkVal("wbSameCycleRd1", bus.RD1E, BYP ? 32'hdead_beef : 32'h0);
      step(32'h00018293, 32'h204, 1'b0, 1'b0, 5'd0, 32'h0);
      checkVal("wbNextCycleRd1", bus.RD1E, 32'hdead_beef);

      // x0 write attempt while reading x0 (addi x5,x0,0)
      step(32'h00000293, 32'h208, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
      checkVal("x0SameCycleRd1", bus.RD1E, 32'h0);
      step(32'h00000293, 32'h20c, 1'b0, 1'b0, 5'd0, 32'h0);
      checkVal("x0NextCycleRd1", bus.RD1E, 32'h0);

      for (int n = 0; n < 400; n++) begin
         ins    = randInstr();
         pc     = $urandom & 32'hffff_fffc;
         fl     = ($urandom_range(0, 7) == 0);
         wbEn   = 1'($urandom_range(0, 1));
         wbRd   = ($urandom_range(0, 3) == 0) ? ins[19:15] : 5'($urandom_range(0, 31));
         wbData = $urandom;
         predict(ins, pc, fl, wbEn, wbRd, wbData, e, ck);
         step(ins, pc, fl, wbEn, wbRd, wbData);
         checkOut($sformatf("rand%0d", n), e, ck);
      end

      // asynchronous reset in the middle of a cycle
      step(32'h00a00093, 32'h300, 1'b0, 1'b1, 5'd1, 32'h0000_abcd);
      #2;
      rst = 1'b1;
      bus.instrD = 32'h0; bus.PCD = 32'h0; bus.regWriteW = 1'b0;
      #1 checkOut("rstAsync", '0, 1'b1);
      for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      predict(32'h00008113, 32'h304, 1'b0, 1'b0, 5'd0, 32'h0, e, ck);
      step(32'h00008113, 32'h304, 1'b0, 1'b0, 5'd0, 32'h0);
      checkVal("x1AfterRst", bus.RD1E, 32'h0);
      checkOut("postRstDecode", e, ck);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Second stage of the five-stage RV32I pipeline. Accepts the instruction word and its PC from the fetch stage, decodes control signals, sign-extends the immediate and reads two operands from a 32×32 register file. The register file is written by the write-back stage. All results are registered into the decode/execute pipeline register. Execute consumes these and returns the taken-branch signal used here to flush.

## Interface
Parameters:
- `XLEN`, 32, datapath width (only 32 supported)
- `NREGS`, 32, register count (x0 hardwired zero)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `instrD`  in  32  instruction word from fetch (0x00000000 during fetch reset/stall)
- `PCD`  in  32  PC of `instrD`
- `flushE`  in  1  from execute taken-branch/jump; squash the instruction entering execute
- `regWriteW`  in  1  write-back enable
- `rdW`  in  5  write-back destination
- `resultW`  in  32  write-back data
- `regWriteE`  out  1  write rd in WB
- `resultSrcE`  out  2  00 ALU, 01 memory, 10 PC+4
- `memWriteE`  out  1  store
- `branchE`  out  1  conditional branch (beq)
- `jumpE`  out  1  jal
- `ALUcontrolE`  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- `ALUsrcE`  out  1  0 = RD2E, 1 = immExtE
- `RD1E`, `RD2E`  out  32  operand values of rs1/rs2
- `immExtE`  out  32  sign-extended immediate
- `PCE`  out  32  registered `PCD`
- `rs1E`, `rs2E`, `rdE`  out  5  register indices for the hazard unit
- `illegalE`  out  1  unrecognised opcode

## Operation
- Decode is combinational on `instrD`. Fields: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7b5 [30].
- Supported opcodes:
  - 0000011 lw: I-imm, add, ALUsrc=1, resultSrc=01, regWrite.
  - 0100011 sw: S-imm, add, ALUsrc=1, memWrite.
  - 0110011 R-type: ALU from funct3 and funct7b5. funct3 000 with b5=1 is sub. 000/100/110/111/001/101/010 map to add/xor/or/and/sll/srl/slt.
  - 0010011 I-ALU: same mapping, but funct3 000 is always add.
  - 1100011 beq: B-imm, sub, branch.
  - 1101111 jal: J-imm, jump, resultSrc=10, regWrite.
  - 0110111 lui: U-imm, ALUsrc=1, regWrite. ALU add; execute zeroes operand A for lui.
- Immediates:
  - I: {20{i[31]}, i[31:20]}
  - S: {20{i[31]}, i[31:25], i[11:7]}
  - B: {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}
  - J: {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}
  - U: {i[31:12], 12'b0}
- Any other opcode: all control outputs 0 and `illegalE`=1 next cycle.
- `instrD` = 0x00000000 is a bubble: all control 0 and `illegalE`=0. Fetch emits this word during reset/stall, so it must never raise `illegalE`.
- Register file:
  - Two combinational read ports (rs1, rs2) and one write port.
  - Write on rising edge when `regWriteW` && `rdW`≠0.
  - x0 always reads 0.
- The D/E register captures all decoded outputs, RD1/RD2, the immediate, `PCD` and the indices.

## Timing
- Latency is one cycle: the instruction present on `instrD` in cycle n appears on the *E outputs in cycle n+1.
- Reset:
  - Every output is 0 while `rst` is high and after release until the first capture edge.
  - All 32 registers are cleared to 0.
  - Reset mid-operation discards the in-flight D/E contents immediately (asynchronous).
- `flushE`=1 at an edge: the D/E register loads the bubble (all outputs 0, including `PCE` and indices). The register file write in that same edge still occurs.
- Write-back and read of the same register in the same cycle:
  - With bypass (see Configuration), `RD1E`/`RD2E` capture `resultW`.
  - Without bypass, they capture the old value.
- x0 write attempts are ignored in all modes, and bypass never applies to index 0.

## Configuration
- Macro `DECODE_WB_BYPASS_EN`.
- Defined: read ports forward `resultW` when `regWriteW` && `rdW`==rs && rs≠0. This removes the WB→D hazard.
- Undefined: plain register-file read. The hazard unit must stall one extra cycle for WB→D dependencies.

## Test plan
- Assert `rst` mid-stream with `instrD`=0x00a00093 → all E outputs 0 immediately. After release, read of x1 returns 0.
- Sequence:
  - `instrD`=0x00500093 (addi x1,x0,5) → next cycle `regWriteE`=1, `ALUsrcE`=1, `immExtE`=5, `ALUcontrolE`=000, `rdE`=1.
  - `instrD`=0xfe208ee3 (beq x1,x2,-4) → `branchE`=1, `ALUcontrolE`=001, `immExtE`=0xfffffffc.
- Write x3=0xdeadbeef via WB while `instrD` reads rs1=x3:
  - With `DECODE_WB_BYPASS_EN` → `RD1E`=0xdeadbeef.
  - Without → `RD1E`=0; the same read one cycle later returns 0xdeadbeef.
- WB write to x0 with `resultW`=0x1234 → subsequent `RD1E` for rs1=x0 is 0, both with and without bypass.
- `instrD`=0x0000006f (jal x0,0) with `flushE`=1 on the same edge → all E outputs 0. Next instruction 0x00000000 → `illegalE`=0. Opcode 0x7f → `illegalE`=1 with all control 0.
